// File: rtl/menu_pkg.sv
// Shared definitions for the menu selection controller: state encoding,
// default timing constants and a counter-width helper.
package menu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'b00,
      ST_BROWSE    = 2'b01,
      ST_CONFIRMED = 2'b10
   } menu_state_t;

   localparam int DEF_NUM_ITEMS     = 6;
   localparam int DEF_IDX_W         = 3;
   localparam int DEF_DB_CYCLES     = 16;
   localparam int DEF_REPEAT_DELAY  = 50;
   localparam int DEF_REPEAT_PERIOD = 10;

   // Bits needed to hold the value maxval (at least one bit).
   function automatic int cnt_width(input int maxval);
      return (maxval < 2) ? 1 : $clog2(maxval + 1);
   endfunction

endpackage

// File: rtl/btn_conditioner.sv
// One push-button front end: 2-flop synchroniser, counter debounce, rising-edge
// pulse and, when REPEAT_EN is set, hold-to-auto-repeat step pulses.
module btn_conditioner
   import menu_pkg::*;
#(
   parameter int DB_CYCLES     = DEF_DB_CYCLES,
   parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD,
   parameter bit REPEAT_EN     = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic pulse
);

   localparam int DB_W   = cnt_width(DB_CYCLES);
   localparam int RP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RP_W   = cnt_width(RP_MAX);

   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);
   localparam logic [RP_W-1:0] RP_DEL  = RP_W'(REPEAT_DELAY);
   localparam logic [RP_W-1:0] RP_PER  = RP_W'(REPEAT_PERIOD);

   logic            sync_p0, sync_p1;
   logic            lvl_p2, lvl_p3;
   logic [DB_W-1:0] db_cnt;
   logic [RP_W-1:0] rp_cnt;
   logic            rp_period;
   logic            rise;
   logic            rp_fire;

   assign rise = lvl_p2 & ~lvl_p3;

   // rp_cnt counts cycles since the last step; it only matters while the level is held.
   always_comb begin
      rp_fire = 1'b0;
      if (REPEAT_EN && lvl_p2 && lvl_p3)
         rp_fire = (rp_cnt == (rp_period ? RP_PER : RP_DEL));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_p0   <= 1'b0;
         sync_p1   <= 1'b0;
         lvl_p2    <= 1'b0;
         lvl_p3    <= 1'b0;
         db_cnt    <= '0;
         rp_cnt    <= '0;
         rp_period <= 1'b0;
         pulse     <= 1'b0;
      end else begin
         // stage 0/1: synchroniser
         sync_p0 <= btn;
         sync_p1 <= sync_p0;

         // stage 2: debounced level flips after DB_CYCLES differing samples
         if (sync_p1 == lvl_p2) begin
            db_cnt <= '0;
         end else if (db_cnt == DB_LAST) begin
            lvl_p2 <= ~lvl_p2;
            db_cnt <= '0;
         end else begin
            db_cnt <= db_cnt + 1'b1;
         end

         // stage 3: edge pulse and auto-repeat
         lvl_p3 <= lvl_p2;
         pulse  <= rise | rp_fire;

         if (!lvl_p2) begin
            rp_cnt    <= '0;
            rp_period <= 1'b0;
         end else if (rise || rp_fire) begin
            rp_cnt    <= RP_W'(1);
            rp_period <= rp_fire;
         end else if (rp_cnt != '1) begin
            rp_cnt <= rp_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/menu_select_ctrl.sv
// Button-driven item selector: four conditioned buttons feed a small FSM that
// walks a wrapping index, locks a choice on ok and unlocks it on back.
module menu_select_ctrl
   import menu_pkg::*;
#(
   parameter int NUM_ITEMS     = DEF_NUM_ITEMS,
   parameter int IDX_W         = DEF_IDX_W,
   parameter int DB_CYCLES     = DEF_DB_CYCLES,
   parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             btn_up,
   input  logic             btn_down,
   input  logic             btn_ok,
   input  logic             btn_back,
   output logic [IDX_W-1:0] sel_idx,
   output logic             sel_valid,
   output logic             locked,
   output logic [1:0]       state_o
);

   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_ITEMS - 1);

   logic        up_step, dn_step, ok_press, back_press;
   menu_state_t state;

   btn_conditioner #(
      .DB_CYCLES(DB_CYCLES), .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD), .REPEAT_EN(1'b1)
   ) u_up (.clk(clk), .rst(rst), .btn(btn_up), .pulse(up_step));

   btn_conditioner #(
      .DB_CYCLES(DB_CYCLES), .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD), .REPEAT_EN(1'b1)
   ) u_down (.clk(clk), .rst(rst), .btn(btn_down), .pulse(dn_step));

   btn_conditioner #(
      .DB_CYCLES(DB_CYCLES), .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD), .REPEAT_EN(1'b0)
   ) u_ok (.clk(clk), .rst(rst), .btn(btn_ok), .pulse(ok_press));

   btn_conditioner #(
      .DB_CYCLES(DB_CYCLES), .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD), .REPEAT_EN(1'b0)
   ) u_back (.clk(clk), .rst(rst), .btn(btn_back), .pulse(back_press));

   assign state_o = state;

   // enable=0 overrides every press; the index is kept across IDLE.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         sel_idx   <= '0;
         sel_valid <= 1'b0;
         locked    <= 1'b0;
      end else begin
         sel_valid <= 1'b0;
         if (!enable) begin
            state  <= ST_IDLE;
            locked <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: begin
                  state <= ST_BROWSE;
               end
               ST_BROWSE: begin
                  if (ok_press) begin
                     state     <= ST_CONFIRMED;
                     sel_valid <= 1'b1;
                     locked    <= 1'b1;
                  end else if (up_step && !dn_step) begin
                     sel_idx <= (sel_idx == IDX_LAST) ? '0 : sel_idx + 1'b1;
                  end else if (dn_step && !up_step) begin
                     sel_idx <= (sel_idx == '0) ? IDX_LAST : sel_idx - 1'b1;
                  end
               end
               ST_CONFIRMED: begin
                  if (back_press) begin
                     state  <= ST_BROWSE;
                     locked <= 1'b0;
                  end
               end
               default: begin
                  state  <= ST_IDLE;
                  locked <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
